// File: rtl/alu_md.sv
// alu_md: MIPS EX-stage ALU with single-cycle logic/arith ops and an
// iterative multiply/divide unit owning the architectural HI/LO registers.
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             overflow,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MFHI = 4'b1100;
    localparam logic [3:0] OP_MFLO = 4'b1101;
    localparam logic [3:0] OP_MTHI = 4'b1110;
    localparam logic [3:0] OP_MTLO = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    // acc_hi/acc_lo: partial product (mult) or remainder/quotient (div)
    logic [WIDTH-1:0] acc_hi, acc_lo, dvsr;
    logic             neg_q, neg_r, is_div, div0;

    logic             is_md, sgn_op, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] add_r, sub_r, alu_y;
    logic             ovf_add, ovf_sub, alu_ov;
    logic [WIDTH:0]   mul_sum, div_sh, div_dif;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign in_ready = (state == IDLE);
    assign zero     = (y == '0);
    assign is_md    = (op[3:2] == 2'b10);

    // Signed variants (op[0]=0) work on magnitudes; signs are reapplied in FIX
    assign sgn_op = ~op[0];
    assign sa     = sgn_op & a[WIDTH-1];
    assign sb     = sgn_op & b[WIDTH-1];
    assign abs_a  = sa ? -a : a;
    assign abs_b  = sb ? -b : b;

    assign add_r   = a + b;
    assign sub_r   = a - b;
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);

    // One iteration step: shift-add for mult, restoring shift-subtract for div
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvsr} : '0);
    assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
    assign div_dif = div_sh - {1'b0, dvsr};

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -acc_lo : acc_lo;
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;

    // Single-cycle result and overflow selection
    always_comb begin
        alu_y  = '0;
        alu_ov = 1'b0;
        case (op)
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_ADD:  begin alu_y = add_r; alu_ov = ovf_add; end
            OP_XOR:  alu_y = a ^ b;
            OP_NOR:  alu_y = ~(a | b);
            OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SUB:  begin alu_y = sub_r; alu_ov = ovf_sub; end
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: alu_y = hi;
            OP_MFLO: alu_y = lo;
            default: alu_y = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state; flush wins over completion, ignored in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid && is_md) state_nx = BUSY;
            BUSY: begin
                if (flush)                         state_nx = IDLE;
                else if (cnt == CW'(WIDTH - 1))    state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: result/flag registers, HI/LO, iterative unit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            is_div    <= 1'b0;
            div0      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    if (is_md) begin
                        acc_hi <= '0;
                        acc_lo <= abs_a;
                        dvsr   <= abs_b;
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        is_div <= op[1];
                        div0   <= (b == '0);
                        cnt    <= '0;
                    end else begin
                        y         <= alu_y;
                        overflow  <= alu_ov;
                        out_valid <= 1'b1;
                        if (op == OP_MTHI) hi <= a;
                        if (op == OP_MTLO) lo <= a;
                    end
                end
                BUSY: begin
                    if (is_div) begin
                        if (!div_dif[WIDTH]) begin
                            acc_hi <= div_dif[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_sh[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt != CW'(WIDTH - 1)) cnt <= cnt + 1'b1;
                end
                FIX: if (!flush) begin
                    if (is_div) begin
                        // Divide by zero: quotient all ones; the remainder
                        // path already reproduces the raw dividend
                        lo <= div0 ? '1 : quot_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    y         <= '0;
                    overflow  <= 1'b0;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed + randomized checks of alu_md against an arithmetic model.
module tb_alu_md;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, flush;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, overflow, zero;
    logic [W-1:0] y, hi, lo;

    int tests = 0;
    int fails = 0;

    // model state
    logic [W-1:0] m_hi, m_lo, m_y;
    logic         m_ov;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .y(y), .out_valid(out_valid),
        .overflow(overflow), .zero(zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural model from plain arithmetic
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        longint s, q, r, lim;
        logic [2*W-1:0] p;
        lim  = longint'(1) <<< (W - 1);
        m_y  = '0;
        m_ov = 1'b0;
        case (o)
            4'd0: m_y = x & z;
            4'd1: m_y = x | z;
            4'd2: begin
                s = longint'($signed(x)) + longint'($signed(z));
                m_y = x + z; m_ov = (s >= lim) || (s < -lim);
            end
            4'd3: m_y = x ^ z;
            4'd4: m_y = ~(x | z);
            4'd5: m_y = (x < z) ? 1 : 0;
            4'd6: begin
                s = longint'($signed(x)) - longint'($signed(z));
                m_y = x - z; m_ov = (s >= lim) || (s < -lim);
            end
            4'd7: m_y = ($signed(x) < $signed(z)) ? 1 : 0;
            4'd8: begin
                p = {{W{x[W-1]}}, x} * {{W{z[W-1]}}, z};
                m_hi = p[2*W-1:W]; m_lo = p[W-1:0];
            end
            4'd9: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, z};
                m_hi = p[2*W-1:W]; m_lo = p[W-1:0];
            end
            4'd10: begin
                if (z == 0) begin m_lo = '1; m_hi = x; end
                else begin
                    q = longint'($signed(x)) / longint'($signed(z));
                    r = longint'($signed(x)) % longint'($signed(z));
                    m_lo = q[W-1:0]; m_hi = r[W-1:0];
                end
            end
            4'd11: begin
                if (z == 0) begin m_lo = '1; m_hi = x; end
                else begin m_lo = x / z; m_hi = x % z; end
            end
            4'd12: m_y = m_hi;
            4'd13: m_y = m_lo;
            4'd14: m_hi = x;
            default: m_lo = x;
        endcase
    endtask

    // Issue one op (called just after a clock edge), wait for its completion, check everything
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        int n, low;
        model(o, x, z);
        in_valid = 1'b1; op = o; a = x; b = z;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (o[3:2] == 2'b10) begin
            n = 0;
            low = in_ready ? 0 : 1;
            while (!out_valid && n < 200) begin
                @(posedge clk); #1;
                n++;
                if (!in_ready) low++;
            end
            chk($sformatf("md_latency op%0d", o), 64'(n), 64'(W + 1));
            chk($sformatf("md_busy_cycles op%0d", o), 64'(low), 64'(W + 1));
            chk($sformatf("md_ready op%0d", o), 64'(in_ready), 64'(1));
        end
        chk($sformatf("out_valid op%0d", o), 64'(out_valid), 64'(1));
        chk($sformatf("y op%0d a=%0h b=%0h", o, x, z), 64'(y), 64'(m_y));
        chk($sformatf("overflow op%0d", o), 64'(overflow), 64'(m_ov));
        chk($sformatf("zero op%0d", o), 64'(zero), 64'(m_y == 0));
        chk($sformatf("hi op%0d a=%0h b=%0h", o, x, z), 64'(hi), 64'(m_hi));
        chk($sformatf("lo op%0d a=%0h b=%0h", o, x, z), 64'(lo), 64'(m_lo));
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return '1;
            3:       return W'($urandom_range(0, 15));
            4:       return -W'($urandom_range(1, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0; m_y = '0; m_ov = 1'b0;

        // reset state
        #12;
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_zero", 64'(zero), 64'(1));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // directed single-cycle ops
        run_op(4'd2, 32'h7FFF_FFFF, 32'h1);
        @(posedge clk); #1;
        chk("out_valid_pulse", 64'(out_valid), 64'(0));
        chk("y_hold", 64'(y), 64'(32'h8000_0000));
        run_op(4'd6, 32'd5, 32'd5);
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd1);
        run_op(4'd4, 32'd0, 32'd0);
        run_op(4'd6, 32'h8000_0000, 32'd1);

        // mult/div directed
        run_op(4'd8, -32'd3, 32'd5);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd2);
        run_op(4'd13, 32'd0, 32'd0);
        run_op(4'd10, -32'd7, 32'd2);
        run_op(4'd11, 32'd9, 32'd0);
        run_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(4'd10, -32'd9, 32'd0);
        run_op(4'd12, 32'd0, 32'd0);

        // flush during DIV; in_valid pulses while busy are ignored
        run_op(4'd14, 32'h1234, 32'd0);
        run_op(4'd15, 32'h5678, 32'd0);
        in_valid = 1'b1; op = 4'b1010; a = 32'd100; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("flush_busy_ready", 64'(in_ready), 64'(0));
        for (int i = 1; i < 10; i++) begin
            in_valid = (i >= 3 && i <= 5); op = 4'd2; a = 32'd1; b = 32'd1;
            @(posedge clk); #1;
            chk("busy_no_out", 64'(out_valid), 64'(0));
        end
        flush = 1'b1; in_valid = 1'b1; op = 4'd2;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_ready", 64'(in_ready), 64'(1));
        chk("flush_no_out", 64'(out_valid), 64'(0));
        chk("flush_hi", 64'(hi), 64'(32'h1234));
        chk("flush_lo", 64'(lo), 64'(32'h5678));
        chk("flush_y", 64'(y), 64'(m_y));
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_no_late_out", 64'(seen), 64'(0));

        // flush in IDLE does not block an accept
        flush = 1'b1;
        run_op(4'd2, 32'd3, 32'd4);
        flush = 1'b0;

        // randomized mix, back-to-back single-cycle ops
        for (int i = 0; i < 300; i++) begin
            run_op(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
        end

        // async reset mid-MULT
        run_op(4'd2, 32'h1111, 32'h2222);
        in_valid = 1'b1; op = 4'd8; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("arst_y", 64'(y), 64'(0));
        chk("arst_zero", 64'(zero), 64'(1));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_overflow", 64'(overflow), 64'(0));
        chk("arst_hi", 64'(hi), 64'(0));
        chk("arst_lo", 64'(lo), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        #1 rst = 1'b0;
        m_hi = '0; m_lo = '0; m_y = '0;
        @(posedge clk); #1;
        run_op(4'd2, 32'd5, 32'd6);
        run_op(4'd9, 32'd3, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised next-generation ALU for the MIPS datapath.
- Extends the AND/OR/ADD/SUB/SLT set with XOR, NOR and SLTU.
- Adds a multi-cycle multiply/divide unit with architectural HI/LO registers.
- Uses a valid/ready handshake. Sits in EX; the pipeline stalls on in_ready=0.

Parameters:
WIDTH, 32, operand/result width in bits (>=8). Iterative unit takes WIDTH iteration cycles.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operation request
in_ready  output  1  high when the unit can accept an operation (state IDLE)
op  input  4  operation code (see Behaviour)
a  input  WIDTH  operand A (rs; dividend/multiplicand)
b  input  WIDTH  operand B (rt; divisor/multiplier)
flush  input  1  abort any in-flight mult/div
y  output  WIDTH  registered result
out_valid  output  1  one-cycle pulse: y/flags (or HI/LO) updated
overflow  output  1  registered signed overflow of ADD/SUB
zero  output  1  (y == 0), combinational from registered y
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, active-high): y=0, out_valid=0, overflow=0, hi=0, lo=0, state=IDLE, iteration counter=0; zero=1 as a consequence of y=0. Reset mid-operation discards the operation.
- Accept: occurs on a clk edge with in_valid & in_ready. in_ready = (state==IDLE).
- op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed): same low-3-bit encoding as the existing ALU.
  - 0011 XOR, 0100 NOR, 0101 SLTU.
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
  - 1100 MFHI, 1101 MFLO, 1110 MTHI (hi<=a), 1111 MTLO (lo<=a).
- Single-cycle ops (op[3]=0, MFHI/MFLO/MTHI/MTLO):
  - On the accept edge: y, overflow and out_valid=1 are registered. Latency 1; back-to-back accepts allowed.
  - ADD/SUB arithmetic is modulo 2^WIDTH.
  - overflow is set only for ADD/SUB with signed overflow, and 0 for every other op. Overflow does not suppress y.
  - SLT/SLTU: y = {0..0, lt}.
  - MTHI/MTLO: y=0.
- Mult/div FSM: IDLE -> BUSY -> FIX -> IDLE.
  - Accept edge E0: latch |a|, |b| (signed ops take the magnitude; unsigned ops use operands as-is), record result signs, counter=0, state=BUSY.
  - BUSY: one shift-add (MULT) or restoring shift-subtract (DIV) step per edge, edges E1..E(WIDTH); counter reaches WIDTH-1 at EWIDTH, then state=FIX.
  - FIX, edge E(WIDTH+1):
    - Apply sign correction. Product is negated if signs differ. Quotient is negated if signs differ; remainder takes the dividend's sign.
    - Write {hi,lo}: mult gives hi=upper half, lo=lower half; div gives lo=quotient, hi=remainder.
    - y<=0, overflow<=0, out_valid<=1, state=IDLE.
  - Accept-to-out_valid latency is WIDTH+1 edges. in_ready returns high in the same cycle out_valid is high.
- Divide by zero (DIV/DIVU, b=0): lo = all ones, hi = a (raw operand). Still takes full latency.
- DIV of most-negative by -1: lo = most-negative, hi = 0, no flag.
- hi/lo are untouched by any op except mult/div completion and MTHI/MTLO.
- flush:
  - Ignored in IDLE; it does not block an accept in the same cycle.
  - In BUSY/FIX: next edge state=IDLE; hi/lo unchanged; no out_valid.
  - Takes priority over FIX completion on the same edge.
- in_valid while in_ready=0 is ignored; the operation is not queued.
- out_valid is low in every cycle without a completion; y holds its last value.

Test Plan:
- ADD a=0x7FFFFFFF b=0x00000001, WIDTH=32 -> next cycle y=0x80000000, overflow=1, zero=0, out_valid=1 for one cycle. SUB a=b=5 -> y=0, zero=1, overflow=0.
- SLT a=0xFFFFFFFF b=1 -> y=1; SLTU same operands -> y=0. NOR a=0 b=0 -> y=0xFFFFFFFF.
- MULT a=-3 b=5 -> in_ready=0 for 33 cycles, out_valid 33 edges after accept, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=0xFFFFFFFF b=2 -> hi=1, lo=0xFFFFFFFE. Then MFLO -> y=lo after 1 cycle.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=9 b=0 -> lo=0xFFFFFFFF, hi=9. DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
- MTHI 0x1234 / MTLO 0x5678, then DIV with flush asserted on iteration 10 -> in_ready=1 next cycle, no out_valid, hi=0x1234, lo=0x5678. in_valid pulses during BUSY produce no effect.
- rst asserted asynchronously mid-MULT (between clock edges) -> outputs reach reset values immediately; after deassertion in_ready=1 and a new ADD completes with latency 1.
